// File: rtl/modred_pipe.sv
// rtl/modred_pipe.sv - five-stage streaming Montgomery reduction D = A*R^-1 mod P
module modred_pipe #(
  parameter int PW = 255,
  parameter int RW = 256,
  parameter int AW = 510,
  parameter logic [PW-1:0] P = (255'd5 << 248) - 255'd1,
  parameter logic [RW-1:0] MU = (256'd1 << 250) + (256'd1 << 248) + 256'd1,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] A,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] D,
  output logic [TW-1:0] out_tag
);

  localparam int QW = PW + RW;
  localparam int TLW = PW + 1;

  // Stage registers: valid chain, tag chain, and per-stage datapath values
  logic [4:0]    valid;
  logic [TW-1:0] tag_q [5];
  logic [AW-1:0] a0, a1, a2;
  logic [RW-1:0] m1;
  logic [QW-1:0] mq2;
  logic [PW:0]   t3;
  logic [PW-1:0] d4;

  // Whole pipeline advances in lockstep; a held output freezes every stage
  logic en;
  assign en        = !valid[4] | out_ready;
  assign in_ready  = en;
  assign out_valid = valid[4];
  assign D         = d4;
  assign out_tag   = tag_q[4];

  // m only needs the low RW bits of the product, so the multiply is RW wide
  logic [RW-1:0] m_next;
  assign m_next = a0[RW-1:0] * MU;

  // m*P kept at full width; truncating here would corrupt the carry into t
  logic [QW-1:0] mq_next;
  assign mq_next = {{PW{1'b0}}, m1} * {{RW{1'b0}}, P};

  // Low RW bits of the sum cancel to zero, so the shift discards nothing
  logic [QW:0] s_next;
  logic [PW:0] t_next;
  assign s_next = {1'b0, mq2} + {{(QW + 1 - AW){1'b0}}, a2};
  assign t_next = TLW'(s_next >> RW);

  // t < 2P, so a single conditional subtraction lands in [0, P)
  logic [PW-1:0] d_sub;
  logic [PW-1:0] d_next;
  assign d_sub  = t3[PW-1:0] - P;
  assign d_next = (t3 >= {1'b0, P}) ? d_sub : t3[PW-1:0];

  // Shift every stage forward when enabled; reset discards all in-flight work
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < 5; i++) tag_q[i] <= '0;
      a0  <= '0;
      a1  <= '0;
      a2  <= '0;
      m1  <= '0;
      mq2 <= '0;
      t3  <= '0;
      d4  <= '0;
    end else if (en) begin
      valid    <= {valid[3:0], in_valid};
      tag_q[0] <= in_tag;
      for (int i = 1; i < 5; i++) tag_q[i] <= tag_q[i-1];
      a0  <= A;
      a1  <= a0;
      a2  <= a1;
      m1  <= m_next;
      mq2 <= mq_next;
      t3  <= t_next;
      d4  <= d_next;
    end
  end

endmodule
